decode_cycle: RTL and testbench

Instruction-decode stage placed directly downstream of the fetch stage. It consumes the IF/ID register outputs (instruction, PC, PC+4) and performs the following:
- reads the 32x32 register file
- generates main and ALU control
- sign-extends the immediate
- registers everything into the ID/EX pipeline register that feeds the execute stage

It also hosts the register-file write port driven from writeback.

---
 rtl/decode_cycle.sv | 226 ++++++++++++++++++++++
 tb/tb_decode_cycle.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/decode_cycle.sv
// decode_cycle -- RV32I instruction-decode stage.
//
// Reads the register file for the instruction held in IF/ID and generates
// main/ALU control. It sign-extends the immediate and registers the result
// into the ID/EX pipeline register that feeds execute. It also owns the
// register-file write port driven from writeback.
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-low reset
//   en, clr             ID/EX enable (0 = stall) and flush (only when en=1)
//   InstrD, PCD, PCPlus4D  IF/ID register contents
//   RegWriteW, RdW, ResultW  writeback write port
//   Rs1D, Rs2D          combinational source fields for the hazard unit
//   *E                  registered ID/EX outputs
//
// Optional feature macro: WB_BYPASS_EN
//   defined   -> a same-cycle writeback to a register being read is forwarded
//                to the read data (write-before-read)
//   undefined -> reads see the pre-edge array; the hazard unit must stall
module decode_cycle #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            clr,
  input  logic [31:0]     InstrD,
  input  logic [XLEN-1:0] PCD,
  input  logic [XLEN-1:0] PCPlus4D,
  input  logic            RegWriteW,
  input  logic [4:0]      RdW,
  input  logic [XLEN-1:0] ResultW,
  output logic [4:0]      Rs1D,
  output logic [4:0]      Rs2D,
  output logic            RegWriteE,
  output logic            MemWriteE,
  output logic            BranchE,
  output logic            JumpE,
  output logic            PCJalSrcE,
  output logic            ALUSrcE,
  output logic            ALUSrcAE,
  output logic [1:0]      ResultSrcE,
  output logic [3:0]      ALUControlE,
  output logic [2:0]      Funct3E,
  output logic [XLEN-1:0] RD1E,
  output logic [XLEN-1:0] RD2E,
  output logic [XLEN-1:0] ImmExtE,
  output logic [XLEN-1:0] PCE,
  output logic [XLEN-1:0] PCPlus4E,
  output logic [4:0]      Rs1E,
  output logic [4:0]      Rs2E,
  output logic [4:0]      RdE
);

  typedef struct packed {
    logic            reg_write;
    logic            mem_write;
    logic            branch;
    logic            jump;
    logic            pc_jal_src;
    logic            alu_src;
    logic            alu_src_a;
    logic [1:0]      result_src;
    logic [3:0]      alu_control;
    logic [2:0]      funct3;
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic [XLEN-1:0] imm_ext;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
  } idex_t;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  logic [6:0] opcode;
  logic [2:0] funct3;
  assign opcode = InstrD[6:0];
  assign funct3 = InstrD[14:12];
  assign Rs1D   = InstrD[19:15];
  assign Rs2D   = InstrD[24:20];

  // ---------------- register file ----------------
  // Reset clears the whole array so x1..x31 start at zero; x0 is never
  // written and is masked to zero on read anyway.
  logic [XLEN-1:0] rf_reg [NREGS];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREGS; i++) rf_reg[i] <= '0;
    end else if (RegWriteW && (RdW != 5'd0)) begin
      rf_reg[RdW] <= ResultW;
    end
  end

  // Two identical read ports: port 0 on rs1, port 1 on rs2.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_read
      logic [4:0]      idx;
      logic [XLEN-1:0] data;
      assign idx = (gi == 0) ? InstrD[19:15] : InstrD[24:20];
      always_comb begin
        data = (idx == 5'd0) ? '0 : rf_reg[idx];
`ifdef WB_BYPASS_EN
        if (RegWriteW && (RdW != 5'd0) && (RdW == idx)) data = ResultW;
`endif
      end
    end
  endgenerate

  // ---------------- decode ----------------
  idex_t idex_next;
  idex_t idex_reg;

  always_comb begin
    idex_next          = '0;
    idex_next.funct3   = funct3;
    idex_next.rd1      = g_read[0].data;
    idex_next.rd2      = g_read[1].data;
    idex_next.pc       = PCD;
    idex_next.pc_plus4 = PCPlus4D;
    idex_next.rs1      = InstrD[19:15];
    idex_next.rs2      = InstrD[24:20];
    idex_next.rd       = InstrD[11:7];

    unique case (opcode)
      OP_R, OP_I: begin
        idex_next.reg_write = 1'b1;
        idex_next.alu_src   = (opcode == OP_I);
        if (opcode == OP_I) idex_next.imm_ext = {{20{InstrD[31]}}, InstrD[31:20]};
        // funct7[5] means sub only for R-type; addi's immediate may set it.
        unique case (funct3)
          3'b000:  idex_next.alu_control = (opcode == OP_R && InstrD[30]) ? 4'b0001 : 4'b0000;
          3'b001:  idex_next.alu_control = 4'b0111;
          3'b010:  idex_next.alu_control = 4'b0101;
          3'b011:  idex_next.alu_control = 4'b0110;
          3'b100:  idex_next.alu_control = 4'b0100;
          3'b101:  idex_next.alu_control = InstrD[30] ? 4'b1001 : 4'b1000;
          3'b110:  idex_next.alu_control = 4'b0011;
          default: idex_next.alu_control = 4'b0010;
        endcase
      end
      OP_LOAD: begin
        idex_next.reg_write  = 1'b1;
        idex_next.alu_src    = 1'b1;
        idex_next.result_src = 2'b01;
        idex_next.imm_ext    = {{20{InstrD[31]}}, InstrD[31:20]};
      end
      OP_STORE: begin
        idex_next.mem_write = 1'b1;
        idex_next.alu_src   = 1'b1;
        idex_next.imm_ext   = {{20{InstrD[31]}}, InstrD[31:25], InstrD[11:7]};
      end
      OP_BR: begin
        idex_next.branch      = 1'b1;
        idex_next.alu_control = 4'b0001;
        idex_next.imm_ext     = {{20{InstrD[31]}}, InstrD[7], InstrD[30:25], InstrD[11:8], 1'b0};
      end
      OP_JAL: begin
        idex_next.jump       = 1'b1;
        idex_next.reg_write  = 1'b1;
        idex_next.result_src = 2'b10;
        idex_next.imm_ext    = {{12{InstrD[31]}}, InstrD[19:12], InstrD[20], InstrD[30:21], 1'b0};
      end
      OP_JALR: begin
        idex_next.jump       = 1'b1;
        idex_next.pc_jal_src = 1'b1;
        idex_next.reg_write  = 1'b1;
        idex_next.alu_src    = 1'b1;
        idex_next.result_src = 2'b10;
        idex_next.imm_ext    = {{20{InstrD[31]}}, InstrD[31:20]};
      end
      OP_LUI: begin
        idex_next.reg_write  = 1'b1;
        idex_next.result_src = 2'b11;
        idex_next.imm_ext    = {InstrD[31:12], 12'b0};
      end
      OP_AUIPC: begin
        idex_next.reg_write = 1'b1;
        idex_next.alu_src   = 1'b1;
        idex_next.alu_src_a = 1'b1;
        idex_next.imm_ext   = {InstrD[31:12], 12'b0};
      end
      default: ;  // unknown opcode or fetch bubble: controls stay 0
    endcase
  end

  // ---------------- ID/EX register ----------------
  // Stall beats flush: with en=0 a pending clr is simply dropped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)     idex_reg <= '0;
    else if (en)  idex_reg <= clr ? '0 : idex_next;
  end

  assign RegWriteE   = idex_reg.reg_write;
  assign MemWriteE   = idex_reg.mem_write;
  assign BranchE     = idex_reg.branch;
  assign JumpE       = idex_reg.jump;
  assign PCJalSrcE   = idex_reg.pc_jal_src;
  assign ALUSrcE     = idex_reg.alu_src;
  assign ALUSrcAE    = idex_reg.alu_src_a;
  assign ResultSrcE  = idex_reg.result_src;
  assign ALUControlE = idex_reg.alu_control;
  assign Funct3E     = idex_reg.funct3;
  assign RD1E        = idex_reg.rd1;
  assign RD2E        = idex_reg.rd2;
  assign ImmExtE     = idex_reg.imm_ext;
  assign PCE         = idex_reg.pc;
  assign PCPlus4E    = idex_reg.pc_plus4;
  assign Rs1E        = idex_reg.rs1;
  assign Rs2E        = idex_reg.rs2;
  assign RdE         = idex_reg.rd;

endmodule

// File: tb/tb_decode_cycle.sv
// Directed bench for decode_cycle: hand-computed expectations checked with
// immediate assertions after each rising edge.
module tb_decode_cycle;
  logic        clk, rst, en, clr;
  logic [31:0] InstrD, PCD, PCPlus4D, ResultW;
  logic        RegWriteW;
  logic [4:0]  RdW;
  logic [4:0]  Rs1D, Rs2D, Rs1E, Rs2E, RdE;
  logic        RegWriteE, MemWriteE, BranchE, JumpE, PCJalSrcE, ALUSrcE, ALUSrcAE;
  logic [1:0]  ResultSrcE;
  logic [3:0]  ALUControlE;
  logic [2:0]  Funct3E;
  logic [31:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E;

  int total = 0;
  int bad   = 0;

  decode_cycle dut (
    .clk(clk), .rst(rst), .en(en), .clr(clr),
    .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
    .RegWriteW(RegWriteW), .RdW(RdW), .ResultW(ResultW),
    .Rs1D(Rs1D), .Rs2D(Rs2D),
    .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .BranchE(BranchE),
    .JumpE(JumpE), .PCJalSrcE(PCJalSrcE), .ALUSrcE(ALUSrcE), .ALUSrcAE(ALUSrcAE),
    .ResultSrcE(ResultSrcE), .ALUControlE(ALUControlE), .Funct3E(Funct3E),
    .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE), .PCE(PCE), .PCPlus4E(PCPlus4E),
    .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE)
  );

  // {RegWrite, MemWrite, Branch, Jump, PCJalSrc, ALUSrc, ALUSrcA, ResultSrc[1:0], ALUControl[3:0]}
  logic [12:0] ctl_e;
  assign ctl_e = {RegWriteE, MemWriteE, BranchE, JumpE, PCJalSrcE, ALUSrcE, ALUSrcAE,
                  ResultSrcE, ALUControlE};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; en = 1'b1; clr = 1'b0;
    InstrD = 32'h00700293; PCD = 32'h0; PCPlus4D = 32'h4;
    RegWriteW = 1'b0; RdW = 5'd0; ResultW = 32'h0;

    // 1. reset held for two edges
    step(); step();
    chk("rst_ctl",    {19'd0, ctl_e}, 32'h0);
    chk("rst_imm",    ImmExtE, 32'h0);
    chk("rst_rd1",    RD1E, 32'h0);
    chk("rst_pc4",    PCPlus4E, 32'h0);
    chk("rst_regs",   {17'd0, Funct3E, Rs1E, Rs2E, RdE}, 32'h0);
    chk("rst_rs2d",   {27'd0, Rs2D}, 32'd7);
    rst = 1'b1;
    step();
    $display("addi x5,x0,7 -> imm=%h rd=%0d ctl=%b", ImmExtE, RdE, ctl_e);
    chk("addi_imm",   ImmExtE, 32'h7);
    chk("addi_rd",    {27'd0, RdE}, 32'd5);
    chk("addi_ctl",   {19'd0, ctl_e}, {19'd0, 13'b1000010_00_0000});
    chk("addi_pc4",   PCPlus4E, 32'h4);

    // 2. write x5 then add x6,x5,x5
    RegWriteW = 1'b1; RdW = 5'd5; ResultW = 32'h00001234;
    step();
    RegWriteW = 1'b0; InstrD = 32'h00528333;
    step();
    $display("add x6,x5,x5 -> rd1=%h rd2=%h", RD1E, RD2E);
    chk("add_rd1",    RD1E, 32'h00001234);
    chk("add_rd2",    RD2E, 32'h00001234);
    chk("add_fields", {17'd0, Rs1E, Rs2E, RdE}, {17'd0, 5'd5, 5'd5, 5'd6});
    chk("add_ctl",    {19'd0, ctl_e}, {19'd0, 13'b1000000_00_0000});

    // 3. write x0 is discarded
    RegWriteW = 1'b1; RdW = 5'd0; ResultW = 32'hFFFFFFFF; InstrD = 32'h00000333;
    step();
    RegWriteW = 1'b0;
    step();
    $display("read x0 -> rd1=%h rd2=%h", RD1E, RD2E);
    chk("x0_rd1",     RD1E, 32'h0);
    chk("x0_rd2",     RD2E, 32'h0);

    // 4. beq x0,x0,-8
    InstrD = 32'hFE000CE3; PCD = 32'h100; PCPlus4D = 32'h104;
    step();
    $display("beq -> imm=%h ctl=%b pc=%h", ImmExtE, ctl_e, PCE);
    chk("beq_imm",    ImmExtE, 32'hFFFFFFF8);
    chk("beq_ctl",    {19'd0, ctl_e}, {19'd0, 13'b0010000_00_0001});
    chk("beq_pc",     PCE, 32'h100);

    // 5. stall two cycles; register-file write still happens (x7)
    en = 1'b0; InstrD = 32'h00528333; PCD = 32'h200; PCPlus4D = 32'h204;
    RegWriteW = 1'b1; RdW = 5'd7; ResultW = 32'h11111111;
    step();
    RegWriteW = 1'b0;
    step();
    $display("stall -> ctl=%b imm=%h pc=%h rd=%0d", ctl_e, ImmExtE, PCE, RdE);
    chk("stall_ctl",  {19'd0, ctl_e}, {19'd0, 13'b0010000_00_0001});
    chk("stall_imm",  ImmExtE, 32'hFFFFFFF8);
    chk("stall_pc",   PCE, 32'h100);
    chk("stall_rd",   {27'd0, RdE}, 32'd25);
    clr = 1'b1;  // stall + flush: flush lost
    step();
    chk("stallclr_ctl", {19'd0, ctl_e}, {19'd0, 13'b0010000_00_0001});
    chk("stallclr_pc",  PCE, 32'h100);
    en = 1'b1;   // flush
    step();
    $display("flush -> ctl=%b imm=%h pc=%h", ctl_e, ImmExtE, PCE);
    chk("flush_ctl",  {19'd0, ctl_e}, 32'h0);
    chk("flush_imm",  ImmExtE, 32'h0);
    chk("flush_pc",   PCE, 32'h0);
    chk("flush_rd1",  RD1E, 32'h0);
    chk("flush_regs", {17'd0, Funct3E, Rs1E, Rs2E, RdE}, 32'h0);
    clr = 1'b0; InstrD = 32'h00000000;
    step();
    $display("bubble -> ctl=%b pc=%h", ctl_e, PCE);
    chk("bubble_ctl", {19'd0, ctl_e}, 32'h0);
    chk("bubble_imm", ImmExtE, 32'h0);
    chk("bubble_pc",  PCE, 32'h200);

    // x7 was written while stalled
    InstrD = 32'h00038433;  // add x8,x7,x0
    step();
    chk("x7_stallwr", RD1E, 32'h11111111);

    // 6. same-cycle write/read of x7
    RegWriteW = 1'b1; RdW = 5'd7; ResultW = 32'hA5A5A5A5;
    step();
    $display("same-cycle x7 -> rd1=%h", RD1E);
`ifdef WB_BYPASS_EN
    chk("bypass_rd1", RD1E, 32'hA5A5A5A5);
`else
    chk("nobyp_rd1",  RD1E, 32'h11111111);
`endif
    RegWriteW = 1'b0;
    step();
    chk("x7_after",   RD1E, 32'hA5A5A5A5);

    // Decode coverage
    InstrD = 32'h403150B3;  step();  // sra x1,x2,x3
    chk("sra_ctl",    {19'd0, ctl_e}, {19'd0, 13'b1000000_00_1001});
    chk("sra_imm",    ImmExtE, 32'h0);
    InstrD = 32'h40000033;  step();  // sub
    chk("sub_ctl",    {19'd0, ctl_e}, {19'd0, 13'b1000000_00_0001});
    InstrD = 32'h40000093;  step();  // addi x1,x0,0x400 (bit30 set, still add)
    chk("addi4_ctl",  {19'd0, ctl_e}, {19'd0, 13'b1000010_00_0000});
    chk("addi4_imm",  ImmExtE, 32'h00000400);
    InstrD = 32'h4020D093;  step();  // srai x1,x1,2
    chk("srai_ctl",   {19'd0, ctl_e}, {19'd0, 13'b1000010_00_1001});
    chk("srai_imm",   ImmExtE, 32'h00000402);
    InstrD = 32'h12345537;  step();  // lui x10,0x12345
    chk("lui_ctl",    {19'd0, ctl_e}, {19'd0, 13'b1000000_11_0000});
    chk("lui_imm",    ImmExtE, 32'h12345000);
    InstrD = 32'h008000EF;  step();  // jal x1,8
    chk("jal_ctl",    {19'd0, ctl_e}, {19'd0, 13'b1001000_10_0000});
    chk("jal_imm",    ImmExtE, 32'h00000008);
    InstrD = 32'h00008067;  step();  // jalr x0,0(x1)
    chk("jalr_ctl",   {19'd0, ctl_e}, {19'd0, 13'b1001110_10_0000});
    InstrD = 32'h00001297;  step();  // auipc x5,1
    chk("auipc_ctl",  {19'd0, ctl_e}, {19'd0, 13'b1000011_00_0000});
    chk("auipc_imm",  ImmExtE, 32'h00001000);
    InstrD = 32'hFE512E23;  step();  // sw x5,-4(x2)
    $display("sw -> ctl=%b imm=%h f3=%0d", ctl_e, ImmExtE, Funct3E);
    chk("sw_ctl",     {19'd0, ctl_e}, {19'd0, 13'b0100010_00_0000});
    chk("sw_imm",     ImmExtE, 32'hFFFFFFFC);
    chk("sw_f3",      {29'd0, Funct3E}, 32'd2);
    chk("sw_rd2",     RD2E, 32'h00001234);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
